// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE tile sequencer: FSM states, tile count/index
// triples and the zero-count clamp applied when a job latches its limits.
package redmule_pkg;

    localparam int unsigned TileCntWidth = 16;

    typedef logic [TileCntWidth-1:0] cnt_t;

    typedef enum logic [2:0] {
        SEQ_IDLE    = 3'd0,
        SEQ_LOAD    = 3'd1,
        SEQ_COMPUTE = 3'd2,
        SEQ_STORE   = 3'd3,
        SEQ_DONE    = 3'd4
    } seq_state_e;

    typedef struct packed {
        cnt_t m;
        cnt_t n;
        cnt_t k;
    } tile_cnt_t;

    // A zero tile count still means one tile of work.
    function automatic cnt_t clamp_cnt(input cnt_t c);
        return (c == '0) ? cnt_t'(1) : c;
    endfunction

endpackage

// File: rtl/redmule_tile_sequencer_if.sv
// Memory and engine side of the tile sequencer. Handshake: a req stays high until the
// cycle its gnt is sampled with it; a gnt seen while req is low has no effect.
interface redmule_tile_sequencer_if #(
    parameter int unsigned CntWidth = 16
) ();

    logic                x_req_o;
    logic                x_gnt_i;
    logic                w_req_o;
    logic                w_gnt_i;
    logic                z_req_o;
    logic                z_gnt_i;
    logic                eng_start_o;
    logic                eng_done_i;
    logic                acc_en_o;
    logic [CntWidth-1:0] m_idx_o;
    logic [CntWidth-1:0] n_idx_o;
    logic [CntWidth-1:0] k_idx_o;

    modport master (
        output x_req_o, w_req_o, z_req_o, eng_start_o, acc_en_o,
        output m_idx_o, n_idx_o, k_idx_o,
        input  x_gnt_i, w_gnt_i, z_gnt_i, eng_done_i
    );

    modport slave (
        input  x_req_o, w_req_o, z_req_o, eng_start_o, acc_en_o,
        input  m_idx_o, n_idx_o, k_idx_o,
        output x_gnt_i, w_gnt_i, z_gnt_i, eng_done_i
    );

endinterface

// File: rtl/redmule_tile_counter.sv
// Nested m/n/k tile counter with limits latched at job start; k is innermost and the
// walk stops (no wrap) once the last (m,n) tile has been stored.
module redmule_tile_counter
    import redmule_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      clr_i,
    input  logic      load_i,
    input  tile_cnt_t cnt_i,
    input  logic      step_k_i,
    input  logic      step_store_i,
    output tile_cnt_t idx_o,
    output logic      last_k_o,
    output logic      last_all_o
);

    tile_cnt_t lim_q, lim_d;
    tile_cnt_t idx_q, idx_d;
    logic      last_n, last_m;

    assign last_k_o   = (idx_q.k == lim_q.k - cnt_t'(1));
    assign last_n     = (idx_q.n == lim_q.n - cnt_t'(1));
    assign last_m     = (idx_q.m == lim_q.m - cnt_t'(1));
    assign last_all_o = last_n && last_m;
    assign idx_o      = idx_q;

    always_comb begin
        lim_d = lim_q;
        idx_d = idx_q;
        if (clr_i) begin
            lim_d = '0;
            idx_d = '0;
        end else if (load_i) begin
            lim_d.m = clamp_cnt(cnt_i.m);
            lim_d.n = clamp_cnt(cnt_i.n);
            lim_d.k = clamp_cnt(cnt_i.k);
            idx_d   = '0;
        end else if (step_store_i) begin
            idx_d.k = '0;
            if (!last_n) begin
                idx_d.n = idx_q.n + cnt_t'(1);
            end else if (!last_m) begin
                idx_d.n = '0;
                idx_d.m = idx_q.m + cnt_t'(1);
            end
        end else if (step_k_i && !last_k_o) begin
            idx_d.k = idx_q.k + cnt_t'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lim_q <= '0;
            idx_q <= '0;
        end else begin
            lim_q <= lim_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/redmule_tile_sequencer.sv
// Tile-level sequencer: walks the m/n/k tile nest issuing X/W loads, engine starts and
// Z stores, and reports the first W grant of a job back to the controller.
module redmule_tile_sequencer
    import redmule_pkg::*;
#(
    parameter int unsigned CntWidth = TileCntWidth
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     first_load_i,
    input  logic                     sched_rst_i,
    input  logic [CntWidth-1:0]      m_tiles_i,
    input  logic [CntWidth-1:0]      n_tiles_i,
    input  logic [CntWidth-1:0]      k_tiles_i,
    redmule_tile_sequencer_if.master bus,
    output logic                     w_loaded_o,
    output logic                     busy_o,
    output logic                     done_o,
    output seq_state_e               state_o
);

    seq_state_e state_q, state_d;
    logic       x_granted_q, x_granted_d;
    logic       w_granted_q, w_granted_d;
    logic       eng_start_q, eng_start_d;
    logic       w_loaded_q, w_loaded_d;
    logic       x_hit, w_hit;
    logic       cnt_clr, cnt_load, step_k, step_store;
    logic       last_k, last_all;
    tile_cnt_t  cnt_in, idx;

    assign cnt_in  = '{m: m_tiles_i, n: n_tiles_i, k: k_tiles_i};
    assign cnt_clr = clear_i || sched_rst_i;

    redmule_tile_counter i_tile_counter (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clr_i        (cnt_clr),
        .load_i       (cnt_load),
        .cnt_i        (cnt_in),
        .step_k_i     (step_k),
        .step_store_i (step_store),
        .idx_o        (idx),
        .last_k_o     (last_k),
        .last_all_o   (last_all)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= SEQ_IDLE;
            x_granted_q <= 1'b0;
            w_granted_q <= 1'b0;
            eng_start_q <= 1'b0;
            w_loaded_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_granted_q <= x_granted_d;
            w_granted_q <= w_granted_d;
            eng_start_q <= eng_start_d;
            w_loaded_q  <= w_loaded_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_granted_d = x_granted_q;
        w_granted_d = w_granted_q;
        eng_start_d = 1'b0;
        w_loaded_d  = w_loaded_q;
        cnt_load    = 1'b0;
        step_k      = 1'b0;
        step_store  = 1'b0;
        // A grant only counts while its request is actually outstanding.
        x_hit       = (state_q == SEQ_LOAD) && !x_granted_q && bus.x_gnt_i;
        w_hit       = (state_q == SEQ_LOAD) && !w_granted_q && bus.w_gnt_i;
        if (cnt_clr) begin
            state_d     = SEQ_IDLE;
            x_granted_d = 1'b0;
            w_granted_d = 1'b0;
            w_loaded_d  = 1'b0;
        end else begin
            if (w_hit) w_loaded_d = 1'b1;
            unique case (state_q)
                SEQ_IDLE: begin
                    if (first_load_i) begin
                        cnt_load = 1'b1;
                        state_d  = SEQ_LOAD;
                    end
                end
                SEQ_LOAD: begin
                    x_granted_d = x_granted_q || x_hit;
                    w_granted_d = w_granted_q || w_hit;
                    if (x_granted_d && w_granted_d) begin
                        x_granted_d = 1'b0;
                        w_granted_d = 1'b0;
                        eng_start_d = 1'b1;
                        state_d     = SEQ_COMPUTE;
                    end
                end
                SEQ_COMPUTE: begin
                    if (bus.eng_done_i) begin
                        if (last_k) begin
                            state_d = SEQ_STORE;
                        end else begin
                            step_k  = 1'b1;
                            state_d = SEQ_LOAD;
                        end
                    end
                end
                SEQ_STORE: begin
                    if (bus.z_gnt_i) begin
                        step_store = 1'b1;
                        state_d    = last_all ? SEQ_DONE : SEQ_LOAD;
                    end
                end
                SEQ_DONE: state_d = SEQ_DONE;
                default:  state_d = SEQ_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.x_req_o     = (state_q == SEQ_LOAD) && !x_granted_q;
        bus.w_req_o     = (state_q == SEQ_LOAD) && !w_granted_q;
        bus.z_req_o     = (state_q == SEQ_STORE);
        bus.eng_start_o = eng_start_q;
        bus.acc_en_o    = ((state_q == SEQ_LOAD) || (state_q == SEQ_COMPUTE)) && (idx.k != '0);
        bus.m_idx_o     = idx.m;
        bus.n_idx_o     = idx.n;
        bus.k_idx_o     = idx.k;
        w_loaded_o      = w_loaded_q;
        busy_o          = (state_q != SEQ_IDLE);
        done_o          = (state_q == SEQ_DONE);
        state_o         = state_q;
    end

endmodule

// File: tb/tb_redmule_tile_sequencer.sv
// Bench for redmule_tile_sequencer: randomized memory/engine responders, a tile-order
// reference built from plain nested loops, and per-cycle handshake checks.
module tb_redmule_tile_sequencer;
    import redmule_pkg::*;

    localparam int W  = 3*TileCntWidth + 1;
    localparam int ZW = 2*TileCntWidth;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        first_load;
    logic        sched_rst;
    logic [15:0] m_tiles, n_tiles, k_tiles;
    logic        w_loaded, busy, done;
    seq_state_e  state;

    logic [W-1:0]  exp_q[$];
    logic [ZW-1:0] exp_z_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    redmule_tile_sequencer_if #(.CntWidth(16)) bus ();

    redmule_tile_sequencer #(.CntWidth(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear),
        .first_load_i (first_load),
        .sched_rst_i  (sched_rst),
        .m_tiles_i    (m_tiles),
        .n_tiles_i    (n_tiles),
        .k_tiles_i    (k_tiles),
        .bus          (bus),
        .w_loaded_o   (w_loaded),
        .busy_o       (busy),
        .done_o       (done),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] out_vec();
        logic [63:0] v;
        v = {8'd0, bus.x_req_o, bus.w_req_o, bus.z_req_o, bus.eng_start_o, bus.acc_en_o,
             w_loaded, busy, done, bus.m_idx_o, bus.n_idx_o, bus.k_idx_o};
        return v;
    endfunction

    task automatic zero_inputs();
        clear          = 1'b0;
        first_load     = 1'b0;
        sched_rst      = 1'b0;
        bus.x_gnt_i    = 1'b0;
        bus.w_gnt_i    = 1'b0;
        bus.z_gnt_i    = 1'b0;
        bus.eng_done_i = 1'b0;
    endtask

    // mode 0: random latencies plus spurious inputs; 1: fixed latencies;
    // 2: first load has W granted 5 cycles before X, later loads grant both together.
    function automatic int gnt_delay(input int mode, input int load_no, input bit is_x);
        if (mode == 1) return 1;
        if (mode == 2) return (load_no == 0) ? (is_x ? 5 : 0) : 1;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic run_job(input int m, input int n, input int k, input int mode,
                           input bit abort_store);
        int mm, nn, kk, starts, accs, zs, cyc, load_no, xw, ww, zw, cw;
        bit xg, wg, start_pend, wl, x_drop, w_drop, z_drop, fin;
        logic [W-1:0]  exp_t;
        logic [ZW-1:0] exp_z;
        mm = (m == 0) ? 1 : m;
        nn = (n == 0) ? 1 : n;
        kk = (k == 0) ? 1 : k;
        starts = 0; accs = 0; zs = 0; cyc = 0; load_no = 0;
        xw = -1; ww = -1; zw = -1; cw = -1;
        xg = 0; wg = 0; start_pend = 0; wl = 0; x_drop = 0; w_drop = 0; z_drop = 0; fin = 0;
        exp_q.delete();
        exp_z_q.delete();
        for (int mi = 0; mi < mm; mi++) begin
            for (int ni = 0; ni < nn; ni++) begin
                for (int ki = 0; ki < kk; ki++)
                    exp_q.push_back({16'(mi), 16'(ni), 16'(ki), (ki != 0)});
                exp_z_q.push_back({16'(mi), 16'(ni)});
            end
        end
        @(negedge clk);
        first_load = 1'b1;
        m_tiles = 16'(m); n_tiles = 16'(n); k_tiles = 16'(k);
        @(negedge clk);
        first_load = 1'b0;
        m_tiles = 16'($urandom); n_tiles = 16'($urandom); k_tiles = 16'($urandom);
        while (!fin && cyc < 4000) begin
            check("eng_start", 64'(bus.eng_start_o), 64'(start_pend));
            check("w_loaded", 64'(w_loaded), 64'(wl));
            if (x_drop) check("x_req_drop", 64'(bus.x_req_o), 64'(0));
            if (w_drop) check("w_req_drop", 64'(bus.w_req_o), 64'(0));
            if (z_drop) check("z_req_drop", 64'(bus.z_req_o), 64'(0));
            start_pend = 0; x_drop = 0; w_drop = 0; z_drop = 0;
            if (bus.eng_start_o) begin
                exp_t = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                check("start_tile", 64'({bus.m_idx_o, bus.n_idx_o, bus.k_idx_o, bus.acc_en_o}),
                      64'(exp_t));
                starts++;
                accs += int'(bus.acc_en_o);
                cw = (mode == 1) ? 4 : int'($urandom_range(0, 4));
            end
            if (done) begin
                fin = 1;
            end else begin
                zero_inputs();
                if (bus.x_req_o) begin
                    if (xw < 0) xw = gnt_delay(mode, load_no, 1'b1);
                    if (xw == 0) begin
                        bus.x_gnt_i = 1'b1; xg = 1; x_drop = 1; xw = -1;
                    end else xw--;
                end else if (mode == 0 && $urandom_range(0, 3) == 0) bus.x_gnt_i = 1'b1;
                if (bus.w_req_o) begin
                    if (ww < 0) ww = gnt_delay(mode, load_no, 1'b0);
                    if (ww == 0) begin
                        bus.w_gnt_i = 1'b1; wg = 1; w_drop = 1; ww = -1; wl = 1;
                    end else ww--;
                end else if (mode == 0 && $urandom_range(0, 3) == 0) bus.w_gnt_i = 1'b1;
                if (xg && wg) begin
                    start_pend = 1; xg = 0; wg = 0; load_no++;
                end
                if (cw >= 0) begin
                    if (cw == 0) begin
                        bus.eng_done_i = 1'b1; cw = -1;
                    end else cw--;
                end else if (mode == 0 && state != SEQ_COMPUTE && $urandom_range(0, 3) == 0) begin
                    bus.eng_done_i = 1'b1;
                end
                if (bus.z_req_o) begin
                    if (zw < 0) begin
                        exp_z = (exp_z_q.size() != 0) ? exp_z_q.pop_front() : '1;
                        check("store_tile", 64'({bus.m_idx_o, bus.n_idx_o}), 64'(exp_z));
                        zs++;
                        if (abort_store) begin
                            zero_inputs();
                            rst_n = 1'b0;
                            #1;
                            check("async_rst_outs", out_vec(), 64'(0));
                            check("async_rst_state", 64'(state), 64'(SEQ_IDLE));
                            #2 rst_n = 1'b1;
                            return;
                        end
                        zw = (mode == 0) ? int'($urandom_range(0, 3)) : 1;
                    end
                    if (zw == 0) begin
                        bus.z_gnt_i = 1'b1; z_drop = 1; zw = -1;
                    end else zw--;
                end else if (mode == 0 && $urandom_range(0, 3) == 0) bus.z_gnt_i = 1'b1;
                @(negedge clk);
                cyc++;
            end
        end
        check("job_finished", 64'(fin), 64'(1));
        check("start_count", 64'(starts), 64'(mm*nn*kk));
        check("acc_start_count", 64'(accs), 64'(mm*nn*(kk-1)));
        check("store_count", 64'(zs), 64'(mm*nn));
        check("exp_left", 64'(exp_q.size() + exp_z_q.size()), 64'(0));
        check("done_flags", 64'({busy, done}), 64'(2'b11));
        check("done_state", 64'(state), 64'(SEQ_DONE));
        for (int i = 0; i < 3; i++) begin
            first_load = 1'b1; bus.x_gnt_i = 1'b1; bus.w_gnt_i = 1'b1;
            bus.z_gnt_i = 1'b1; bus.eng_done_i = 1'b1;
            @(negedge clk);
            check("done_hold", 64'({done, bus.x_req_o, bus.w_req_o, bus.z_req_o, bus.eng_start_o}),
                  64'(5'b10000));
        end
        zero_inputs();
        sched_rst = 1'b1;
        @(negedge clk);
        sched_rst = 1'b0;
        check("sched_rst_outs", out_vec(), 64'(0));
        check("sched_rst_state", 64'(state), 64'(SEQ_IDLE));
    endtask

    task automatic clear_test();
        @(negedge clk);
        first_load = 1'b1;
        m_tiles = 16'd2; n_tiles = 16'd2; k_tiles = 16'd2;
        @(negedge clk);
        first_load = 1'b0;
        bus.x_gnt_i = 1'b1; bus.w_gnt_i = 1'b1;
        @(negedge clk);
        bus.x_gnt_i = 1'b0; bus.w_gnt_i = 1'b0;
        check("clr_setup_start", 64'(bus.eng_start_o), 64'(1));
        check("clr_setup_state", 64'(state), 64'(SEQ_COMPUTE));
        check("clr_setup_wl", 64'(w_loaded), 64'(1));
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_outs", out_vec(), 64'(0));
        check("clear_state", 64'(state), 64'(SEQ_IDLE));
        for (int i = 0; i < 3; i++) begin
            bus.eng_done_i = 1'b1; bus.z_gnt_i = 1'b1; bus.x_gnt_i = 1'b1; bus.w_gnt_i = 1'b1;
            @(negedge clk);
            check("idle_spurious", out_vec(), 64'(0));
        end
        zero_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        zero_inputs();
        m_tiles = '0; n_tiles = '0; k_tiles = '0;
        repeat (2) @(negedge clk);
        check("reset_outs", out_vec(), 64'(0));
        check("reset_state", 64'(state), 64'(SEQ_IDLE));
        rst_n = 1'b1;

        run_job(1, 1, 1, 1, 1'b0);
        run_job(2, 3, 4, 0, 1'b0);
        run_job(1, 1, 3, 2, 1'b0);
        run_job(2, 2, 0, 0, 1'b0);
        clear_test();
        run_job(1, 2, 1, 0, 1'b1);
        run_job(1, 1, 2, 0, 1'b0);
        for (int i = 0; i < 4; i++)
            run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
